barrett_seq_ctrl: RTL and testbench
===================================

Name: barrett_seq_ctrl

Overview:
Upstream sequencer and result stage for the digit-serial Barrett multiplier core (Barrett_4, n=8, m=4).
- Accepts one operand set (A, B, M, mu) over a valid/ready handshake.
- Pulses the core's reset, holds X/M/mu steady, and streams B as m-bit digits MSB-first after one leading zero digit.
- Captures the core's (n+1)-bit Z, applies the final conditional subtraction(s) of M, and presents the n-bit residue downstream on a valid/ready handshake.

Parameters:
- n, 8, operand width; must be a multiple of m.
- m, 4, digit width; core processes D = n/m + 1 digits per product.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  sequencer can accept an operand set.
- a_in  in  n  multiplicand A; caller guarantees A < M.
- b_in  in  n  multiplier B; caller guarantees B < M.
- m_in  in  n  modulus M; nonzero.
- mu_in  in  m+5  Barrett constant for M.
- core_rst  out  1  active-low reset to the core.
- core_carry_add  out  1  tied 0.
- core_carry_sub  out  1  tied 1.
- core_x  out  n  latched A.
- core_y_i  out  m  current B digit.
- core_m  out  n  latched M.
- core_mu  out  m+5  latched mu.
- core_z  in  n+1  core result, partially reduced, range [0, 2M).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- z_out  out  n  fully reduced A*B mod M.

Behaviour:
- Reset (RST=0 at an edge):
  - state goes to IDLE.
  - out_valid=0, in_ready=1 after reset.
  - z_out=0, all latched operands=0, core_y_i=0, digit counter=0.
  - core_rst = RST AND (state != CLR), so the core is also held in reset.
- Reset mid-operation aborts the product. No partial result is ever output.
- FSM states: IDLE, CLR, FEED, CORR, DONE (plus CORR2 with the optional feature).
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_in, b_in, m_in, mu_in; set the counter to D-1; go to CLR.
- CLR (1 cycle):
  - core_rst=0; core_y_i=0.
  - Go to FEED.
- FEED (exactly D cycles):
  - First cycle: core_y_i = 0 (leading zero digit).
  - Then core_y_i = B[(k-1)*m +: m] for k = D-1 down to 1, i.e. MSB digit first.
  - Counter decrements each cycle. At counter=0 after the last digit, go to CORR.
- CORR (1 cycle):
  - Compute t = core_z; if t >= M then t = t - M. Compare in n+1 bits.
  - Register z_out = t[n-1:0] and go to DONE.
- DONE:
  - out_valid=1.
  - z_out and all core_* outputs stay stable while out_ready=0.
  - On out_ready=1: out_valid drops at the next edge; go to IDLE.
- in_ready=0 in every state except IDLE. The earliest next acceptance is the cycle after the output handshake.
- Latency: the accepting cycle is cycle 0; out_valid rises in cycle D+3 (6 for n=8, m=4). Throughput is one product per D+4 cycles minimum.
- in_valid is ignored outside IDLE. Inputs may change freely after acceptance.
- t == M exactly: the result is 0. t == M-1: no subtraction.

Optional Feature:
- Macro: BARRETT_DOUBLE_CORR_EN.
- Defined:
  - Adds a CORR2 state between CORR and DONE that applies a second conditional subtraction.
  - Accepts core_z in [0, 3M).
  - Latency becomes D+4.
- Undefined:
  - Single subtraction only.
  - core_z >= 2M yields the unreduced value t-M truncated to n bits. No error flag.

Decomposition:
- Shared package barrett_pkg:
  - state enum (IDLE/CLR/FEED/CORR/CORR2/DONE).
  - localparam D = n/m + 1.
  - digit-count width $clog2(D+1).
- Sub-module barrett_mod_corr: combinational conditional-subtract (inputs t[n:0], M; output t or t-M). Instantiated once, or twice with the macro.
- Everything else stays in the top-level FSM.

Test Plan:
- Digit order: B=0xA5, A=0x11, M=0xFB, core stubbed. Expect core_rst low for exactly 1 cycle, then core_y_i = 0x0, 0xA, 0x5 on consecutive cycles; core_x=0x11 held throughout.
- Full product with real core: A=200, B=150, M=251, matching mu. Expect z_out=131, out_valid 6 cycles after acceptance.
- Correction boundaries with stub core, M=251:
  - core_z=258 -> z_out=7.
  - core_z=250 -> z_out=250.
  - core_z=251 -> z_out=0.
  - With BARRETT_DOUBLE_CORR_EN, core_z=505 -> z_out=3.
- Backpressure: out_ready=0 for 5 cycles in DONE. Expect z_out and out_valid stable, in_ready=0 throughout, and in_valid pulses ignored. Raise out_ready: next edge out_valid=0, in_ready=1.
- Reset mid-FEED: RST=0 on the 2nd FEED cycle. Next edge: state IDLE, out_valid=0, z_out=0, core_rst=0 while RST low. A new operand set after RST=1 completes correctly.
- Back-to-back: 50 random (A, B < M) sets with in_valid held high and out_ready=1. Expect every z_out to equal the golden (A*B mod M), with no dropped or duplicated results.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared definitions for the Barrett multiplier sequencer: FSM states and
// default digit geometry (n=8, m=4).
package barrett_pkg;

  localparam int N_W   = 8;
  localparam int M_W   = 4;
  localparam int D     = N_W / M_W + 1;
  localparam int CNT_W = $clog2(D + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FEED  = 3'd2,
    CORR  = 3'd3,
    CORR2 = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/barrett_mod_corr.sv
// Conditional subtraction of the modulus: returns t - M when t >= M, else t.
// Both sides are compared in n+1 bits so a partially reduced t up to 2^(n+1)-1 is handled.
module barrett_mod_corr #(
  parameter int n = 8
) (
  input  logic [n:0]   t_i,
  input  logic [n-1:0] mod_i,
  output logic [n:0]   t_o
);

  logic [n:0] mod_ext;

  assign mod_ext = {1'b0, mod_i};

  always_comb begin
    t_o = t_i;
    if (t_i >= mod_ext) t_o = t_i - mod_ext;
  end

endmodule

// File: rtl/barrett_seq_ctrl.sv
// Sequencer and result stage for the digit-serial Barrett core: feeds B as m-bit digits
// MSB-first behind a leading zero, then reduces the core's Z. Optional macro BARRETT_DOUBLE_CORR_EN.
module barrett_seq_ctrl
  import barrett_pkg::*;
#(
  parameter int n = N_W,
  parameter int m = M_W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a_in,
  input  logic [n-1:0]   b_in,
  input  logic [n-1:0]   m_in,
  input  logic [m+4:0]   mu_in,
  output logic           core_rst,
  output logic           core_carry_add,
  output logic           core_carry_sub,
  output logic [n-1:0]   core_x,
  output logic [m-1:0]   core_y_i,
  output logic [n-1:0]   core_m,
  output logic [m+4:0]   core_mu,
  input  logic [n:0]     core_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [n-1:0]   z_out
);

  localparam int DIG = n / m + 1;
  localparam int CW  = $clog2(DIG + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [n-1:0]    x_q, x_d;
  logic [n-1:0]    b_q, b_d;
  logic [n-1:0]    mod_q, mod_d;
  logic [m+4:0]    mu_q, mu_d;
  logic [n-1:0]    z_q, z_d;
  logic [n:0]      corr1_t;

  // Counter value DIG-1 matches no digit index, which yields the leading zero digit.
  function automatic logic [m-1:0] pick_digit(input logic [n-1:0] b, input logic [CW-1:0] k);
    pick_digit = '0;
    for (int i = 0; i < n / m; i++) begin
      if (k == CW'(i)) pick_digit = b[i*m +: m];
    end
  endfunction

  barrett_mod_corr #(.n(n)) u_corr1 (
    .t_i   (core_z),
    .mod_i (mod_q),
    .t_o   (corr1_t)
  );

`ifdef BARRETT_DOUBLE_CORR_EN
  logic [n:0] t1_q, t1_d;
  logic [n:0] corr2_t;

  barrett_mod_corr #(.n(n)) u_corr2 (
    .t_i   (t1_q),
    .mod_i (mod_q),
    .t_o   (corr2_t)
  );
`else
  logic corr_msb_unused;
  assign corr_msb_unused = corr1_t[n];
`endif

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CLR;
      CLR:     state_d = FEED;
      FEED:    if (cnt_q == '0) state_d = CORR;
`ifdef BARRETT_DOUBLE_CORR_EN
      CORR:    state_d = CORR2;
`else
      CORR:    state_d = DONE;
`endif
      CORR2:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    x_d   = x_q;
    b_d   = b_q;
    mod_d = mod_q;
    mu_d  = mu_q;
    z_d   = z_q;
`ifdef BARRETT_DOUBLE_CORR_EN
    t1_d  = t1_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d   = a_in;
          b_d   = b_in;
          mod_d = m_in;
          mu_d  = mu_in;
          cnt_d = CW'(DIG - 1);
        end
      end
      FEED: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
`ifdef BARRETT_DOUBLE_CORR_EN
      CORR:  t1_d = corr1_t;
      CORR2: z_d  = corr2_t[n-1:0];
`else
      CORR:  z_d  = corr1_t[n-1:0];
`endif
      default: ;
    endcase
  end

  // Operands and result are cleared on reset so an aborted product leaves nothing behind.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
      x_q   <= '0;
      b_q   <= '0;
      mod_q <= '0;
      mu_q  <= '0;
      z_q   <= '0;
`ifdef BARRETT_DOUBLE_CORR_EN
      t1_q  <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
      b_q   <= b_d;
      mod_q <= mod_d;
      mu_q  <= mu_d;
      z_q   <= z_d;
`ifdef BARRETT_DOUBLE_CORR_EN
      t1_q  <= t1_d;
`endif
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    core_y_i  = '0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      FEED:    core_y_i  = pick_digit(b_q, cnt_q);
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign core_rst       = RST & (state_q != CLR);
  assign core_carry_add = 1'b0;
  assign core_carry_sub = 1'b1;
  assign core_x         = x_q;
  assign core_m         = mod_q;
  assign core_mu        = mu_q;
  assign z_out          = z_q;

endmodule

// File: tb/tb_barrett_seq_ctrl.sv
// Randomized bench for barrett_seq_ctrl; the core is stubbed by driving a partially reduced Z.
module tb_barrett_seq_ctrl;

  localparam int N  = 8;
  localparam int MW = 4;
  localparam int DG = N / MW + 1;
`ifdef BARRETT_DOUBLE_CORR_EN
  localparam int LAT = DG + 4;
`else
  localparam int LAT = DG + 3;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_in, b_in, m_in;
  logic [MW+4:0] mu_in;
  logic          core_rst, core_carry_add, core_carry_sub;
  logic [N-1:0]  core_x, core_m;
  logic [MW-1:0] core_y_i;
  logic [MW+4:0] core_mu;
  logic [N:0]    core_z;
  logic          out_valid, out_ready;
  logic [N-1:0]  z_out;

  int n_vec = 0;
  int n_err = 0;

  barrett_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .m_in(m_in), .mu_in(mu_in),
    .core_rst(core_rst), .core_carry_add(core_carry_add), .core_carry_sub(core_carry_sub),
    .core_x(core_x), .core_y_i(core_y_i), .core_m(core_m), .core_mu(core_mu),
    .core_z(core_z), .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N-1:0] modmul(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [N-1:0] md);
    return N'((int'(a) * int'(b)) % int'(md));
  endfunction

  task automatic rand_ops(output logic [N-1:0] a, output logic [N-1:0] b, output logic [N-1:0] md);
    md = N'($urandom_range(2, 255));
    a  = N'($urandom_range(0, int'(md) - 1));
    b  = N'($urandom_range(0, int'(md) - 1));
  endtask

  // Partially reduced core output: the true residue, or residue + M.
  function automatic logic [N:0] partial_z(input logic [N-1:0] r, input logic [N-1:0] md);
    if ($urandom_range(0, 1) == 1) return (N+1)'(int'(r) + int'(md));
    return {1'b0, r};
  endfunction

  task automatic scramble_inputs;
    in_valid = 1'($urandom);
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    m_in     = N'($urandom);
    mu_in    = (MW+5)'($urandom);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] md,
                        input logic [N:0] zc, input logic [N-1:0] exp, input int stall);
    logic [N-1:0]  brec;
    logic [MW-1:0] first;
    logic [MW+4:0] mu_v;
    int lat;
    mu_v      = (MW+5)'($urandom);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    m_in      = md;
    mu_in     = mu_v;
    core_z    = zc;
    out_ready = 1'b1;
    chk_eq("in_ready_idle", in_ready, 1);
    tick;
    lat   = 1;
    brec  = '0;
    first = '1;
    while (!out_valid && lat <= LAT + 4) begin
      chk_eq("core_rst", core_rst, lat != 1);
      chk_eq("in_ready_busy", in_ready, 0);
      chk_eq("core_x", core_x, a);
      chk_eq("core_m", core_m, md);
      chk_eq("core_mu", core_mu, mu_v);
      if (lat == 2) first = core_y_i;
      if (lat >= 2 && lat < 2 + DG) brec = {brec[N-MW-1:0], core_y_i};
      scramble_inputs();
      tick;
      lat++;
    end
    chk_eq("first_digit", first, 0);
    chk_eq("b_digits", brec, b);
    chk_eq("latency", lat, LAT);
    chk_eq("z_out", z_out, exp);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        scramble_inputs();
        tick;
        chk_eq("stall_valid", out_valid, 1);
        chk_eq("stall_z", z_out, exp);
        chk_eq("stall_ready", in_ready, 0);
        chk_eq("stall_x", core_x, a);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk_eq("out_valid_drop", out_valid, 0);
    chk_eq("in_ready_back", in_ready, 1);
    chk_eq("no_reclear", core_rst, 1);
  endtask

  initial begin
    logic [N-1:0] ra, rb, rm, r;
    logic [N-1:0] expq[$];
    int acc, got, cyc;

    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; m_in = '0; mu_in = '0; core_z = '0;
    repeat (3) tick;
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_z_out", z_out, 0);
    chk_eq("rst_core_rst", core_rst, 0);
    chk_eq("rst_core_x", core_x, 0);
    chk_eq("rst_core_y", core_y_i, 0);
    chk_eq("carry_add", core_carry_add, 0);
    chk_eq("carry_sub", core_carry_sub, 1);
    RST = 1'b1;
    tick;
    chk_eq("run_in_ready", in_ready, 1);
    chk_eq("run_core_rst", core_rst, 1);

    run_op(8'h11, 8'hA5, 8'hFB, {1'b0, modmul(8'h11, 8'hA5, 8'hFB)}, modmul(8'h11, 8'hA5, 8'hFB), 0);
    run_op(8'd200, 8'd150, 8'd251, 9'd382, 8'd131, 0);

    rand_ops(ra, rb, rm);
    run_op(ra, rb, 8'd251, 9'd258, 8'd7, 0);
    run_op(rb, ra, 8'd251, 9'd250, 8'd250, 0);
    run_op(ra, ra, 8'd251, 9'd251, 8'd0, 0);
`ifdef BARRETT_DOUBLE_CORR_EN
    run_op(rb, rb, 8'd251, 9'd505, 8'd3, 0);
`else
    run_op(rb, rb, 8'd251, 9'd505, 8'd254, 0);
`endif

    run_op(8'd200, 8'd150, 8'd251, 9'd131, 8'd131, 5);

    // Abort on the second FEED cycle; the held result must be cleared.
    rand_ops(ra, rb, rm);
    in_valid = 1'b1; a_in = ra; b_in = rb; m_in = rm; mu_in = '0;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    RST = 1'b0;
    tick;
    chk_eq("abort_in_ready", in_ready, 1);
    chk_eq("abort_out_valid", out_valid, 0);
    chk_eq("abort_z_out", z_out, 0);
    chk_eq("abort_core_rst", core_rst, 0);
    chk_eq("abort_core_x", core_x, 0);
    RST = 1'b1;
    tick;
    chk_eq("abort_idle", in_ready, 1);
    rand_ops(ra, rb, rm);
    r = modmul(ra, rb, rm);
    run_op(ra, rb, rm, partial_z(r, rm), r, 0);

    for (int i = 0; i < 10; i++) begin
      rand_ops(ra, rb, rm);
      r = modmul(ra, rb, rm);
      run_op(ra, rb, rm, partial_z(r, rm), r, $urandom_range(0, 3));
    end

    // Back-to-back with in_valid held high; operands churn while busy.
    acc = 0; got = 0; cyc = 0;
    rand_ops(ra, rb, rm);
    in_valid = 1'b1; out_ready = 1'b1;
    a_in = ra; b_in = rb; m_in = rm;
    while (got < 50 && cyc < 50 * (DG + 8) + 50) begin
      if (out_valid) begin
        chk_eq("b2b_pending", expq.size() > 0, 1);
        if (expq.size() > 0) chk_eq("b2b_z", z_out, expq.pop_front());
        got++;
      end
      if (in_ready) begin
        if (acc < 50) begin
          r = modmul(a_in, b_in, m_in);
          expq.push_back(r);
          core_z = partial_z(r, m_in);
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        rand_ops(ra, rb, rm);
        a_in = ra; b_in = rb; m_in = rm;
        mu_in = (MW+5)'($urandom);
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    chk_eq("b2b_count", got, 50);
    chk_eq("b2b_leftover", expq.size(), 0);
    repeat (DG + 6) begin
      tick;
      chk_eq("b2b_extra", out_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
